// File: rtl/regfile_bus_arbiter_if.sv
// Requester/register-file bus shared by the two-requester arbiter.
// master = arbiter side, slave = requesters plus register file side.
interface regfile_bus_arbiter_if #(
  parameter int size          = 2,
  parameter int cell_width    = 32,
  parameter int address_width = $clog2(size * size),
  parameter int width         = cell_width * size
);
  // Requester side, two requesters packed (bit/slot 0 host, 1 coprocessor)
  logic [1:0]               in_req_read_en;
  logic [1:0]               in_req_write_en;
  logic [2*address_width-1:0] in_req_address;
  logic [3:0]               in_req_type;
  logic [3:0]               in_req_matrix;
  logic [2*width-1:0]       in_req_data;
  logic [width-1:0]         out_req_data;
  logic [1:0]               out_req_ready;

  // Register file side
  logic [address_width-1:0] out_rf_address;
  logic [1:0]               out_rf_type;
  logic [1:0]               out_rf_matrix;
  logic [width-1:0]         out_rf_data;
  logic                     out_rf_read_en;
  logic                     out_rf_write_en;
  logic [width-1:0]         in_rf_data;

  logic                     out_grant;
  logic                     out_busy;

  modport master (
    input  in_req_read_en, in_req_write_en, in_req_address, in_req_type,
           in_req_matrix, in_req_data, in_rf_data,
    output out_req_data, out_req_ready, out_rf_address, out_rf_type,
           out_rf_matrix, out_rf_data, out_rf_read_en, out_rf_write_en,
           out_grant, out_busy
  );

  modport slave (
    output in_req_read_en, in_req_write_en, in_req_address, in_req_type,
           in_req_matrix, in_req_data, in_rf_data,
    input  out_req_data, out_req_ready, out_rf_address, out_rf_type,
           out_rf_matrix, out_rf_data, out_rf_read_en, out_rf_write_en,
           out_grant, out_busy
  );
endinterface

// File: rtl/regfile_bus_arbiter.sv
// Two-requester (host/coprocessor) arbiter in front of a matrix register file.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to the coprocessor.
module regfile_bus_arbiter #(
  parameter int size          = 2,
  parameter int cell_width    = 32,
  parameter int address_width = $clog2(size * size),
  parameter int width         = cell_width * size
) (
  input logic                   in_clk,
  input logic                   in_reset,
  regfile_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t                   state;
  logic                     op_write;
  logic [1:0]               active;
  logic                     winner;
  logic [address_width-1:0] win_address;
  logic [1:0]               win_type;
  logic [1:0]               win_matrix;
  logic [width-1:0]         win_data;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    active = bus.in_req_read_en | bus.in_req_write_en;
    winner = 1'b0;
    case (active)
      2'b10:   winner = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      2'b11:   winner = ~bus.out_grant;
`else
      2'b11:   winner = 1'b1;
`endif
      default: winner = 1'b0;
    endcase
    win_address = winner ? bus.in_req_address[2*address_width-1:address_width]
                         : bus.in_req_address[address_width-1:0];
    win_type    = winner ? bus.in_req_type[3:2]   : bus.in_req_type[1:0];
    win_matrix  = winner ? bus.in_req_matrix[3:2] : bus.in_req_matrix[1:0];
    win_data    = winner ? bus.in_req_data[2*width-1:width] : bus.in_req_data[width-1:0];
  end

  // NOTE: state and outputs use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      // NOTE: datapath registers are reset as well, since their post-reset value is observable.
      state               <= IDLE;
      op_write            <= 1'b0;
      bus.out_grant       <= 1'b1;
      bus.out_busy        <= 1'b0;
      bus.out_rf_read_en  <= 1'b0;
      bus.out_rf_write_en <= 1'b0;
      bus.out_rf_address  <= '0;
      bus.out_rf_type     <= '0;
      bus.out_rf_matrix   <= '0;
      bus.out_rf_data     <= '0;
      bus.out_req_ready   <= 2'b00;
      bus.out_req_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|active) begin
            // A simultaneous read+write from one requester collapses to a write.
            state               <= ACCESS;
            op_write            <= bus.in_req_write_en[winner];
            bus.out_grant       <= winner;
            bus.out_busy        <= 1'b1;
            bus.out_rf_write_en <= bus.in_req_write_en[winner];
            bus.out_rf_read_en  <= ~bus.in_req_write_en[winner];
            bus.out_rf_address  <= win_address;
            bus.out_rf_type     <= win_type;
            bus.out_rf_matrix   <= win_matrix;
            bus.out_rf_data     <= win_data;
          end
        end
        ACCESS: begin
          state               <= RESPOND;
          bus.out_rf_read_en  <= 1'b0;
          bus.out_rf_write_en <= 1'b0;
          bus.out_req_ready   <= bus.out_grant ? 2'b10 : 2'b01;
          if (!op_write) bus.out_req_data <= bus.in_rf_data;
        end
        RESPOND: begin
          state             <= IDLE;
          bus.out_req_ready <= 2'b00;
          bus.out_busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bus_arbiter.sv
// Directed self-checking bench for regfile_bus_arbiter; follows ARB_ROUND_ROBIN_EN when defined.
module tb_regfile_bus_arbiter;
  localparam int SIZE = 2;
  localparam int CW   = 32;
  localparam int AW   = $clog2(SIZE * SIZE);
  localparam int W    = CW * SIZE;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [2:0] EXP_GRANTS = 3'b010;  // host, coprocessor, host
`else
  localparam logic [2:0] EXP_GRANTS = 3'b111;  // coprocessor every time
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_bus_arbiter_if #(.size(SIZE), .cell_width(CW)) bus ();

  regfile_bus_arbiter #(.size(SIZE), .cell_width(CW)) dut (
    .in_clk  (clk),
    .in_reset(rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.in_req_read_en  = 2'b00;
    bus.in_req_write_en = 2'b00;
    bus.in_req_address  = '0;
    bus.in_req_type     = '0;
    bus.in_req_matrix   = '0;
    bus.in_req_data     = '0;
  endtask

  task automatic test_reset();
    // Request present throughout reset must not be latched.
    bus.in_rf_data      = 64'h0;
    bus.in_req_write_en = 2'b01;
    bus.in_req_address  = {2'd0, 2'd3};
    bus.in_req_matrix   = 4'b0010;
    bus.in_req_data     = {64'h0, 64'hAAAA_BBBB_CCCC_DDDD};
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({bus.out_rf_read_en, bus.out_rf_write_en, bus.out_req_ready, bus.out_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rd=%0b wr=%0b ready=%b busy=%0b expected all 0",
               bus.out_rf_read_en, bus.out_rf_write_en, bus.out_req_ready, bus.out_busy);
    end
    n_tests++;
    if (bus.out_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_grant: got %0b expected 1", bus.out_grant);
    end
    n_tests++;
    if ({bus.out_req_data, bus.out_rf_address, bus.out_rf_type, bus.out_rf_matrix, bus.out_rf_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got req_data=%h rf_addr=%h rf_type=%h rf_mat=%h rf_data=%h expected 0",
               bus.out_req_data, bus.out_rf_address, bus.out_rf_type, bus.out_rf_matrix, bus.out_rf_data);
    end
    clear_reqs();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({bus.out_busy, bus.out_rf_write_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%0b wr=%0b expected 0 0", bus.out_busy, bus.out_rf_write_en);
    end
  endtask

  task automatic test_host_write();
    bus.in_req_write_en = 2'b01;
    bus.in_req_address  = {2'd1, 2'd2};
    bus.in_req_type     = 4'b0100;
    bus.in_req_matrix   = 4'b1001;
    bus.in_req_data     = {64'hDEAD_BEEF_0BAD_F00D, 64'h0000_0005_0000_0007};
    tick();  // edge k: sampled
    clear_reqs();
    n_tests++;
    if ({bus.out_rf_write_en, bus.out_rf_read_en, bus.out_req_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL hw_strobe: got wr=%0b rd=%0b ready=%b expected wr=1 rd=0 ready=00",
               bus.out_rf_write_en, bus.out_rf_read_en, bus.out_req_ready);
    end
    n_tests++;
    if ({bus.out_rf_address, bus.out_rf_type, bus.out_rf_matrix, bus.out_rf_data}
        !== {2'd2, 2'b00, 2'b01, 64'h0000_0005_0000_0007}) begin
      n_fail++;
      $display("FAIL hw_fields: got addr=%h type=%h mat=%h data=%h expected addr=2 type=0 mat=1 data=0000000500000007",
               bus.out_rf_address, bus.out_rf_type, bus.out_rf_matrix, bus.out_rf_data);
    end
    n_tests++;
    if ({bus.out_grant, bus.out_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL hw_grant: got grant=%0b busy=%0b expected grant=0 busy=1", bus.out_grant, bus.out_busy);
    end
    tick();  // cycle k+2
    n_tests++;
    if ({bus.out_req_ready, bus.out_rf_write_en, bus.out_rf_read_en} !== 4'b0100) begin
      n_fail++;
      $display("FAIL hw_ready: got ready=%b wr=%0b rd=%0b expected ready=01 wr=0 rd=0",
               bus.out_req_ready, bus.out_rf_write_en, bus.out_rf_read_en);
    end
    n_tests++;
    if (bus.out_req_data !== 64'h0) begin
      n_fail++;
      $display("FAIL hw_req_data_kept: got %h expected 0", bus.out_req_data);
    end
    tick();
    n_tests++;
    if ({bus.out_req_ready, bus.out_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL hw_done: got ready=%b busy=%0b expected 00 0", bus.out_req_ready, bus.out_busy);
    end
  endtask

  task automatic test_cop_read();
    bus.in_rf_data     = 64'h1111_1111_2222_2222;
    bus.in_req_read_en = 2'b10;
    bus.in_req_address = {2'd0, 2'd3};
    bus.in_req_type    = 4'b0100;
    bus.in_req_matrix  = 4'b0010;
    tick();
    clear_reqs();
    n_tests++;
    if ({bus.out_rf_read_en, bus.out_rf_write_en, bus.out_rf_address, bus.out_rf_matrix, bus.out_rf_type, bus.out_grant}
        !== {1'b1, 1'b0, 2'd0, 2'b00, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL cr_strobe: got rd=%0b wr=%0b addr=%h mat=%h type=%h grant=%0b expected rd=1 wr=0 addr=0 mat=0 type=1 grant=1",
               bus.out_rf_read_en, bus.out_rf_write_en, bus.out_rf_address, bus.out_rf_matrix,
               bus.out_rf_type, bus.out_grant);
    end
    tick();
    n_tests++;
    if ({bus.out_req_ready, bus.out_req_data} !== {2'b10, 64'h1111_1111_2222_2222}) begin
      n_fail++;
      $display("FAIL cr_data: got ready=%b data=%h expected ready=10 data=1111111122222222",
               bus.out_req_ready, bus.out_req_data);
    end
    bus.in_rf_data = 64'h9999_9999_9999_9999;
    tick();
    n_tests++;
    if ({bus.out_req_ready, bus.out_req_data} !== {2'b00, 64'h1111_1111_2222_2222}) begin
      n_fail++;
      $display("FAIL cr_hold: got ready=%b data=%h expected ready=00 data=1111111122222222",
               bus.out_req_ready, bus.out_req_data);
    end
  endtask

  task automatic test_read_write_same();
    int wr_cnt = 0;
    int rd_cnt = 0;
    int rdy_cnt = 0;
    bus.in_req_read_en  = 2'b01;
    bus.in_req_write_en = 2'b01;
    bus.in_req_address  = {2'd0, 2'd1};
    bus.in_req_data     = {64'h0, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) clear_reqs();
      wr_cnt  += int'(bus.out_rf_write_en);
      rd_cnt  += int'(bus.out_rf_read_en);
      rdy_cnt += int'(bus.out_req_ready != 2'b00);
    end
    n_tests++;
    if (wr_cnt != 1 || rd_cnt != 0 || rdy_cnt != 1) begin
      n_fail++;
      $display("FAIL rw_same: got wr=%0d rd=%0d ready=%0d expected wr=1 rd=0 ready=1", wr_cnt, rd_cnt, rdy_cnt);
    end
    n_tests++;
    if (bus.out_req_data !== 64'h1111_1111_2222_2222) begin
      n_fail++;
      $display("FAIL rw_same_data_kept: got %h expected 1111111122222222", bus.out_req_data);
    end
  endtask

  task automatic test_arbitration();
    int          svc = 0;
    int          rsp = 0;
    logic [1:0]  exp_ready;
    rst = 1'b1;
    clear_reqs();
    tick();
    rst = 1'b0;
    bus.in_req_read_en = 2'b11;
    bus.in_req_address = {2'd3, 2'd1};
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.out_rf_read_en && bus.out_rf_write_en) begin
        n_tests++;
        n_fail++;
        $display("FAIL arb_strobes_both: cycle %0d got rd=1 wr=1 expected at most one", i);
      end
      if (bus.out_rf_read_en && svc < 3) begin
        n_tests++;
        if (bus.out_grant !== EXP_GRANTS[svc] || i != 3 * svc) begin
          n_fail++;
          $display("FAIL arb_grant: service %0d got grant=%0b at cycle %0d expected grant=%0b at cycle %0d",
                   svc, bus.out_grant, i, EXP_GRANTS[svc], 3 * svc);
        end
        svc++;
      end
      if (bus.out_req_ready != 2'b00 && rsp < 3) begin
        exp_ready = EXP_GRANTS[rsp] ? 2'b10 : 2'b01;
        n_tests++;
        if (bus.out_req_ready !== exp_ready) begin
          n_fail++;
          $display("FAIL arb_ready: response %0d got %b expected %b", rsp, bus.out_req_ready, exp_ready);
        end
        rsp++;
      end
    end
    n_tests++;
    if (svc != 3 || rsp != 3) begin
      n_fail++;
      $display("FAIL arb_count: got %0d services %0d responses expected 3 3", svc, rsp);
    end
    clear_reqs();
    repeat (3) tick();
  endtask

  task automatic test_reset_in_access();
    int rdy_cnt = 0;
    bus.in_req_write_en = 2'b01;
    bus.in_req_data     = {64'h0, 64'h5555_5555_5555_5555};
    tick();
    n_tests++;
    if (bus.out_rf_write_en !== 1'b1) begin
      n_fail++;
      $display("FAIL ria_access: got wr=%0b expected 1", bus.out_rf_write_en);
    end
    rst = 1'b1;
    clear_reqs();
    tick();
    n_tests++;
    if ({bus.out_rf_read_en, bus.out_rf_write_en, bus.out_req_ready, bus.out_busy, bus.out_grant} !== 6'b000001) begin
      n_fail++;
      $display("FAIL ria_abort: got rd=%0b wr=%0b ready=%b busy=%0b grant=%0b expected 0 0 00 0 1",
               bus.out_rf_read_en, bus.out_rf_write_en, bus.out_req_ready, bus.out_busy, bus.out_grant);
    end
    rst = 1'b0;
    repeat (3) begin
      tick();
      rdy_cnt += int'(bus.out_req_ready != 2'b00);
    end
    n_tests++;
    if (rdy_cnt != 0) begin
      n_fail++;
      $display("FAIL ria_no_ready: got %0d ready pulses expected 0", rdy_cnt);
    end
  endtask

  initial begin
    clear_reqs();
    bus.in_rf_data = '0;
    test_reset();
    test_host_write();
    test_cop_read();
    test_read_write_same();
    test_arbitration();
    test_reset_in_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
